// File: rtl/lu_share_arbiter_pkg.sv
// lu_share_arbiter_pkg: shared FSM states and logic-unit opcodes
package lu_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam logic [1:0] LU_AND  = 2'b00;
  localparam logic [1:0] LU_OR   = 2'b01;
  localparam logic [1:0] LU_XOR  = 2'b10;
  localparam logic [1:0] LU_NOTA = 2'b11;
endpackage

// File: rtl/lu_share_arbiter_lu_core.sv
// lu_core: combinational W-bit bitwise logic unit
import lu_share_arbiter_pkg::*;
module lu_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] g
);
  // bitwise op select; b is unused for NOT A
  always_comb g = op == LU_AND ? a & b : op == LU_OR ? a | b : op == LU_XOR ? a ^ b : ~a;
endmodule

// File: rtl/lu_share_arbiter.sv
// lu_share_arbiter: round-robin sharing of one registered logic unit among NREQ requesters
import lu_share_arbiter_pkg::*;
module lu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 4,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic [7:0]        ops_done
);
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, win;
  logic [1:0] op_q, op_d, sel_op;
  logic [W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, sel_a, sel_b, lu_g;
  logic rsp_valid_q, rsp_valid_d, found;
  logic [7:0] ops_done_q, ops_done_d;
  logic [2*NREQ-1:0] rot;
  logic [IDW:0] sum;
  lu_core #(.W(W)) u_lu (.a(a_q), .b(b_q), .op(op_q), .g(lu_g));
  // round-robin pick: rotate requests so rr_ptr sits at bit 0, take lowest set bit
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr_q;
    found = 1'b0;
    win = '0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      found = 1'b1;
      win = sum >= (IDW+1)'(NREQ) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
    end
  end
  // steer the winner's operands toward the capture registers
  always_comb begin
    sel_op = '0;
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) if (win == IDW'(k)) begin
      sel_op = req_op[2*k +: 2];
      sel_a = req_a[W*k +: W];
      sel_b = req_b[W*k +: W];
    end
  end
  // next-state and grant; grant only in IDLE and never while reset is held
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_data_d = rsp_data_q;
    ops_done_d = ops_done_q;
    req_ready = (state_q == IDLE && found && rst_n) ? NREQ'(1) << win : '0;
    case (state_q)
      IDLE: if (found) begin
        op_d = sel_op;
        a_d = sel_a;
        b_d = sel_b;
        id_d = win;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_data_d = lu_g;
        rsp_id_d = id_q;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        ops_done_d = ops_done_q + 8'd1;
        rr_ptr_d = id_q == IDW'(NREQ - 1) ? '0 : id_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; async reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      ops_done_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      ops_done_q <= ops_done_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign ops_done = ops_done_q;
  assign busy = state_q != IDLE;
endmodule
